// File: rtl/or1200_vlx_unpack_if.sv
// Byte-read bus between the VLX bit unpacker and its memory.
// The unpacker is the master: it requests bytes and memory acks them.
interface or1200_vlx_unpack_if;
  logic        rd_req_o;
  logic [31:0] vlx_addr_o;
  logic [7:0]  dat_i;
  logic        ack_i;

  modport master (
    output rd_req_o,
    output vlx_addr_o,
    input  dat_i,
    input  ack_i
  );

  modport slave (
    input  rd_req_o,
    input  vlx_addr_o,
    output dat_i,
    output ack_i
  );
endinterface

// File: rtl/or1200_vlx_unpack.sv
// VLX unpacker: fetches bytes into a 32-bit MSB-first buffer, serves n-bit reads.
// Define OR1200_VLX_UNPACK_STUFF_EN for FF00 destuffing and marker detection.
module or1200_vlx_unpack (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       spr_cs,
  input  logic                       spr_write,
  input  logic [1:0]                 spr_addr,
  input  logic [31:0]                spr_dat_i,
  output logic [31:0]                spr_dat_o,
  input  logic                       get_bit_op_i,
  input  logic [4:0]                 num_bits_to_read_i,
  output logic [15:0]                bits_o,
  output logic                       stall_cpu_o,
  or1200_vlx_unpack_if.master        mem
);

`ifdef OR1200_VLX_UNPACK_STUFF_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STUFF  = 2'd2,
    MARKER = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;

  logic [4:0]  n;
  logic [5:0]  avail;
  logic [5:0]  rem;
  logic        lack;
  logic        mrk;
  logic [7:0]  code;
  logic        in_rd;
  logic        rd_req;
  logic        acc;
  logic        take;
  logic        restart;
  logic [4:0]  pad_w;
  logic [15:0] pad;
  logic [31:0] buf_sh;
  logic [31:0] ins;

`ifdef OR1200_VLX_UNPACK_STUFF_EN
  logic        mrk_q, mrk_d;
  logic [7:0]  code_q, code_d;

  // The FF held in STUFF is tentative until its follower byte arrives.
  assign in_rd = (state_q == FETCH) | (state_q == STUFF);
  assign avail = (state_q == STUFF) ? cnt_q - 6'd8 : cnt_q;
  assign mrk   = mrk_q;
  assign code  = code_q;
`else
  assign in_rd = state_q == FETCH;
  assign avail = cnt_q;
  assign mrk   = 1'b0;
  assign code  = 8'h00;
`endif

  assign n       = (num_bits_to_read_i > 5'd16) ? 5'd16
                                                : num_bits_to_read_i;
  assign restart = spr_cs & spr_write & (spr_addr == 2'b10);
  assign rd_req  = rst_i & in_rd;
  assign acc     = rd_req & mem.ack_i;
  assign lack    = {1'b0, n} > avail;

  assign stall_cpu_o = rst_i & get_bit_op_i & lack & ~mrk;
  assign take        = rst_i & get_bit_op_i & ~stall_cpu_o;

  // Past a marker the missing low bits read as ones.
  assign pad_w = n - avail[4:0];
  assign pad   = ~(16'hFFFF << pad_w);

  assign bits_o = !rst_i ? 16'h0 :
    (buf_q[31:16] >> (5'd16 - n)) |
    ((lack & mrk) ? pad : 16'h0);

  assign mem.rd_req_o   = rd_req;
  assign mem.vlx_addr_o = addr_q;

  assign spr_dat_o = !spr_cs    ? 32'h0  :
                     spr_addr[1] ? addr_q :
                     {15'h0, mrk, code, 2'b00, cnt_q};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef OR1200_VLX_UNPACK_STUFF_EN
    mrk_d   = mrk_q;
    code_d  = code_q;
`endif
    buf_sh = buf_q;
    rem    = cnt_q;
    if (take) begin
      buf_sh = buf_q << n;
      rem    = lack ? 6'd0 : cnt_q - {1'b0, n};
    end
    ins   = {24'h0, mem.dat_i} << (6'd24 - rem);
    buf_d = buf_sh;
    cnt_d = rem;

    unique case (state_q)
      IDLE: begin
        if (cnt_q <= 6'd24 && !mrk)
          state_d = FETCH;
      end
      FETCH: begin
        if (acc) begin
          buf_d   = buf_sh | ins;
          cnt_d   = rem + 6'd8;
          addr_d  = addr_q + 32'd1;
          state_d = IDLE;
`ifdef OR1200_VLX_UNPACK_STUFF_EN
          if (mem.dat_i == 8'hFF)
            state_d = STUFF;
`endif
        end
      end
`ifdef OR1200_VLX_UNPACK_STUFF_EN
      STUFF: begin
        if (acc) begin
          addr_d = addr_q + 32'd1;
          if (mem.dat_i == 8'h00) begin
            state_d = IDLE;
          end else begin
            cnt_d   = rem - 6'd8;
            buf_d   = buf_sh & ~(32'hFFFF_FFFF >> (rem - 6'd8));
            mrk_d   = 1'b1;
            code_d  = mem.dat_i;
            state_d = MARKER;
          end
        end
      end
      MARKER: begin
        state_d = MARKER;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d = IDLE;
      buf_d   = 32'h0;
      cnt_d   = 6'd0;
      addr_d  = spr_dat_i;
`ifdef OR1200_VLX_UNPACK_STUFF_EN
      mrk_d   = 1'b0;
      code_d  = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      buf_q   <= 32'h0;
      cnt_q   <= 6'd0;
      addr_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

`ifdef OR1200_VLX_UNPACK_STUFF_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mrk_q  <= 1'b0;
      code_q <= 8'h00;
    end else begin
      mrk_q  <= mrk_d;
      code_q <= code_d;
    end
  end
`endif

endmodule
